// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: owner encoding and burst-count width.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CPU = 2'd1, DBG = 2'd2} owner_e;
  localparam int BURST_W = 4;
endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / debug) arbiter in front of a single-port dmem.
// Define DMEM_ARB_PERF_EN to build the conflict / debug-grant counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAXBURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_stall,
  output logic             cpu_rvalid,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic             dbg_lock,
  input  logic [WIDTH-1:0] dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic             dbg_gnt,
  output logic             dbg_rvalid,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  output logic [31:0]      perf_conflicts,
  output logic [31:0]      perf_dbg_gnts
);

  localparam logic [BURST_W-1:0] MAXB = BURST_W'(MAXBURST);

  owner_e             state, state_nxt;
  logic [BURST_W-1:0] burst_cnt, burst_nxt;
  logic               lock_hold;
  logic               cpu_rv_q, dbg_rv_q;

  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    lock_hold = (state == DBG) && dbg_req && dbg_lock && (burst_cnt < MAXB);
    if (!rst) begin
      if (lock_hold)              dbg_gnt = 1'b1;
      else if (cpu_req && dbg_req) begin
        // round-robin: the side that did not own last cycle wins
        if (state == CPU) dbg_gnt = 1'b1;
        else              cpu_gnt = 1'b1;
      end
      else if (cpu_req)           cpu_gnt = 1'b1;
      else if (dbg_req)           dbg_gnt = 1'b1;
    end

    state_nxt = cpu_gnt ? CPU : (dbg_gnt ? DBG : IDLE);

    burst_nxt = burst_cnt;
    if (cpu_gnt || !cpu_req)              burst_nxt = '0;
    else if (dbg_gnt && burst_cnt != MAXB) burst_nxt = burst_cnt + 1'b1;
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we   = dbg_we;
      mem_addr = dbg_addr;
      mem_wd   = dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      cpu_rv_q  <= 1'b0;
      dbg_rv_q  <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      cpu_rv_q  <= cpu_gnt & ~cpu_we;
      dbg_rv_q  <= dbg_gnt & ~dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rd;
      if (dbg_gnt && !dbg_we) dbg_rdata <= mem_rd;
    end
  end

  // a read granted just before reset must not surface during the reset cycle
  assign cpu_rvalid = cpu_rv_q & ~rst;
  assign dbg_rvalid = dbg_rv_q & ~rst;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conf_q, dgnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conf_q <= '0;
      dgnt_q <= '0;
    end else begin
      if (cpu_req && dbg_req) conf_q <= conf_q + 32'd1;
      if (dbg_gnt)            dgnt_q <= dgnt_q + 32'd1;
    end
  end

  assign perf_conflicts = conf_q;
  assign perf_dbg_gnts  = dgnt_q;
`else
  assign perf_conflicts = 32'd0;
  assign perf_dbg_gnts  = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the driver queues expected grants and read
// returns, a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rd;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wd, perf_conflicts, perf_dbg_gnts;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        stall;
  } gnt_exp_t;

  gnt_exp_t    gq[$];
  logic [31:0] cpu_q[$];
  logic [31:0] dbg_q[$];

  dmem_arbiter #(.WIDTH(32), .MAXBURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .perf_conflicts(perf_conflicts), .perf_dbg_gnts(perf_dbg_gnts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // who: 0 none, 1 cpu, 2 dbg. squash suppresses the expected read return.
  task automatic step(input bit creq, input bit cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                      input bit dreq, input bit dwe, input bit dlk,
                      input logic [31:0] daddr, input logic [31:0] dwd,
                      input logic [31:0] mrd, input int who, input bit squash);
    gnt_exp_t e;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_lock = dlk; dbg_addr = daddr; dbg_wdata = dwd;
    mem_rd  = mrd;
    if (who != 0) begin
      e.who   = 2'(who);
      e.we    = (who == 1) ? cwe : dwe;
      e.addr  = (who == 1) ? caddr : daddr;
      e.wd    = (who == 1) ? cwd : dwd;
      e.stall = creq && (who != 1);
      gq.push_back(e);
      if (!e.we && !squash) begin
        if (who == 1) cpu_q.push_back(mrd);
        else          dbg_q.push_back(mrd);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
  endtask

  // monitor
  always @(negedge clk) begin
    gnt_exp_t e;
    logic [31:0] r;
    chk("one_gnt", {31'b0, cpu_gnt & dbg_gnt}, 32'd0);
    if (cpu_gnt || dbg_gnt) begin
      if (gq.size() == 0) chk("unexpected_gnt", {30'b0, dbg_gnt, cpu_gnt}, 32'd0);
      else begin
        e = gq.pop_front();
        chk("gnt_who",   {30'b0, dbg_gnt, cpu_gnt}, {30'b0, e.who});
        chk("mem_we",    {31'b0, mem_we}, {31'b0, e.we});
        chk("mem_addr",  mem_addr, e.addr);
        chk("mem_wd",    mem_wd, e.wd);
        chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, e.stall});
      end
    end else begin
      chk("idle_bus",       {31'b0, mem_we} | mem_addr | mem_wd, 32'd0);
      chk("idle_cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req});
    end
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) chk("unexpected_cpu_rvalid", 32'd1, 32'd0);
      else begin r = cpu_q.pop_front(); chk("cpu_rdata", cpu_rdata, r); end
    end
    if (dbg_rvalid) begin
      if (dbg_q.size() == 0) chk("unexpected_dbg_rvalid", 32'd1, 32'd0);
      else begin r = dbg_q.pop_front(); chk("dbg_rdata", dbg_rdata, r); end
    end
  end

  logic [31:0] exp_conf_b, exp_conf_c, exp_dg_b, exp_dg_c, exp_conf_r;

  initial begin
`ifdef DMEM_ARB_PERF_EN
    exp_conf_b = 32'd4;  exp_dg_b = 32'd2;
    exp_conf_c = 32'd11; exp_dg_c = 32'd9;
    exp_conf_r = 32'd1;
`else
    exp_conf_b = 32'd0;  exp_dg_b = 32'd0;
    exp_conf_c = 32'd0;  exp_dg_c = 32'd0;
    exp_conf_r = 32'd0;
`endif
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = 0; dbg_wdata = 0; mem_rd = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("rst_cpu_rdata",  cpu_rdata, 32'd0);
    chk("rst_dbg_rdata",  dbg_rdata, 32'd0);
    chk("rst_perf_conf",  perf_conflicts, 32'd0);
    chk("rst_perf_dgnt",  perf_dbg_gnts, 32'd0);

    // cpu-only read
    step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1, 0);
    idle();

    // contention from IDLE, no lock: cpu, dbg, cpu, dbg
    step(1, 0, 32'h100, 0, 1, 0, 0, 32'h200, 0, 32'hA0A0_0001, 1, 0);
    step(1, 0, 32'h104, 0, 1, 0, 0, 32'h204, 0, 32'hB0B0_0002, 2, 0);
    step(1, 0, 32'h108, 0, 1, 0, 0, 32'h208, 0, 32'hA0A0_0003, 1, 0);
    step(1, 0, 32'h10C, 0, 1, 0, 0, 32'h20C, 0, 32'hB0B0_0004, 2, 0);
    idle();
    chk("perf_conf_rr", perf_conflicts, exp_conf_b);
    chk("perf_dgnt_rr", perf_dbg_gnts, exp_dg_b);

    // dbg write, leaves owner DBG with a clear burst count
    step(0, 0, 0, 0, 1, 1, 0, 32'h10, 32'h1234_5678, 32'h0, 2, 0);
    chk("dbg_rdata_held", dbg_rdata, 32'hB0B0_0004);

    // locked burst: dbg x4, cpu, dbg x2
    step(1, 1, 32'h300, 32'hC0, 1, 1, 1, 32'h400, 32'hD0, 0, 2, 0);
    step(1, 1, 32'h300, 32'hC0, 1, 1, 1, 32'h404, 32'hD1, 0, 2, 0);
    step(1, 1, 32'h300, 32'hC0, 1, 1, 1, 32'h408, 32'hD2, 0, 2, 0);
    step(1, 1, 32'h300, 32'hC0, 1, 1, 1, 32'h40C, 32'hD3, 0, 2, 0);
    step(1, 1, 32'h300, 32'hC0, 1, 1, 1, 32'h410, 32'hD4, 0, 1, 0);
    step(1, 1, 32'h304, 32'hC1, 1, 1, 1, 32'h410, 32'hD4, 0, 2, 0);
    step(1, 1, 32'h304, 32'hC1, 1, 1, 1, 32'h414, 32'hD5, 0, 2, 0);
    idle();
    chk("perf_conf_lock", perf_conflicts, exp_conf_c);
    chk("perf_dgnt_lock", perf_dbg_gnts, exp_dg_c);

    // granted cpu read, then reset: no rvalid may appear
    step(1, 0, 32'h44, 0, 0, 0, 0, 0, 0, 32'h1111_2222, 1, 1);
    rst = 1'b1;
    step(1, 0, 32'h48, 0, 1, 0, 0, 32'h48, 0, 32'h3333_4444, 0, 0);
    rst = 1'b0;
    chk("post_rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("post_rst_cpu_rdata",  cpu_rdata, 32'd0);
    chk("post_rst_perf_conf",  perf_conflicts, 32'd0);
    chk("post_rst_perf_dgnt",  perf_dbg_gnts, 32'd0);
    // owner back in IDLE: contention goes to cpu
    step(1, 1, 32'h50, 32'h55, 1, 1, 0, 32'h60, 32'h66, 0, 1, 0);
    idle();
    chk("post_rst_perf_conf2", perf_conflicts, exp_conf_r);

    repeat (2) @(posedge clk);
    #1;
    chk("gnt_q_drained",   gq.size(), 32'd0);
    chk("cpu_q_drained",   cpu_q.size(), 32'd0);
    chk("dbg_q_drained",   dbg_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
